// File: rtl/mul_seq.sv
// mul_seq: multi-cycle unsigned shift-add multiplier.
//
// A single N-bit adder (carry-in tied 0) is reused over N iterations to build
// a 2N-bit product. Operands are accepted with a valid/ready handshake and the
// registered product is offered with a second valid/ready handshake.
//
// Optional feature (compile-time macro MUL_SEQ_ZERO_SKIP_EN):
//   defined   - a zero operand goes straight from IDLE to DONE with product 0.
//   undefined - every operation takes the full N iterations.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   operands a/b valid
//   in_ready   out  operands accepted (IDLE only)
//   a          in   N-bit unsigned multiplicand
//   b          in   N-bit unsigned multiplier
//   out_valid  out  product valid (DONE only)
//   out_ready  in   consumer takes product
//   product    out  2N-bit registered product
//   busy       out  iteration in progress (RUN)
module mul_seq #(
    parameter int unsigned N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    localparam int unsigned CntW = $clog2(N + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    hi_q, hi_d;
    logic [N-1:0]    lo_q, lo_d;
    logic [N-1:0]    areg_q, areg_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2*N-1:0]  product_q, product_d;

    // Shared adder: {add_co, add_sum} = hi + areg + 0.
    logic [N:0]   add_full;
    logic [N-1:0] add_sum;
    logic         add_co;

    assign add_full = {1'b0, hi_q} + {1'b0, areg_q};
    assign add_sum  = add_full[N-1:0];
    assign add_co   = add_full[N];

    // One iteration: conditionally add, then shift {c, sum, lo} right by one.
    // The carry lands in bit N-1 of hi, so nothing is ever lost.
    logic [N-1:0] step_hi;
    logic         step_c;
    logic [N-1:0] hi_next;
    logic [N-1:0] lo_next;

    assign step_hi = lo_q[0] ? add_sum : hi_q;
    assign step_c  = lo_q[0] & add_co;
    assign hi_next = {step_c, step_hi[N-1:1]};
    assign lo_next = {step_hi[0], lo_q[N-1:1]};

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        areg_d    = areg_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    areg_d  = a;
                    hi_d    = '0;
                    lo_d    = b;
                    cnt_d   = CntW'(N);
                    state_d = StRun;
`ifdef MUL_SEQ_ZERO_SKIP_EN
                    if ((a == '0) || (b == '0)) begin
                        lo_d      = '0;
                        cnt_d     = '0;
                        product_d = '0;
                        state_d   = StDone;
                    end
`endif
                end
            end
            StRun: begin
                hi_d  = hi_next;
                lo_d  = lo_next;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    // Product register only updates on entry to DONE, so it
                    // keeps the previous result while a new operation runs.
                    product_d = {hi_next, lo_next};
                    state_d   = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            hi_q      <= '0;
            lo_q      <= '0;
            areg_q    <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            areg_q    <= areg_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StRun);
    assign product   = product_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed testbench for mul_seq: an N=8 instance for the handshake, latency
// and reset cases and an N=64 instance for the full-width product.
module tb_mul_seq;

    logic clk;
    logic rst;

    // N = 8 instance
    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;

    // N = 64 instance
    logic         in_valid64, in_ready64, out_valid64, out_ready64, busy64;
    logic [63:0]  a64, b64;
    logic [127:0] product64;

    int checks;
    int failures;

    mul_seq #(.N(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .product   (product8),
        .busy      (busy8)
    );

    mul_seq #(.N(64)) dut64 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid64),
        .in_ready  (in_ready64),
        .a         (a64),
        .b         (b64),
        .out_valid (out_valid64),
        .out_ready (out_ready64),
        .product   (product64),
        .busy      (busy64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one N=8 operation starting at posedge+1. Returns sampled just after
    // out_valid is seen (or the bound expires); out_ready is held at ordy.
    task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic ordy, input logic [15:0] exp, input int exp_lat);
        int lat;
        int busy_n;
        out_ready8 = ordy;
        check_eq({tag, "_idle_rdy"}, in_ready8, 1'b1);
        a8 = ta;
        b8 = tb;
        in_valid8 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        // Operands change after the accept edge and must be ignored.
        a8 = ~ta;
        b8 = ~tb;
        check_eq({tag, "_acc_rdy"}, in_ready8, 1'b0);
        lat = 0;
        busy_n = 0;
        while (!out_valid8 && lat < 24) begin
            busy_n += int'(busy8);
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_busy_cycles"}, busy_n, exp_lat);
        check_eq({tag, "_ovalid"}, out_valid8, 1'b1);
        check_eq({tag, "_prod"}, product8, exp);
        check_eq({tag, "_busy_done"}, busy8, 1'b0);
        if (ordy) begin
            // DONE lasts exactly one cycle with out_ready held high.
            @(posedge clk);
            #1;
            check_eq({tag, "_ovalid_drop"}, out_valid8, 1'b0);
            check_eq({tag, "_rdy_back"}, in_ready8, 1'b1);
            check_eq({tag, "_prod_hold"}, product8, exp);
        end
    endtask

    initial begin
        int lat64;
        int zlat;
        checks = 0;
        failures = 0;
        rst = 1'b1;
        in_valid8 = 1'b0;
        out_ready8 = 1'b0;
        a8 = '0;
        b8 = '0;
        in_valid64 = 1'b0;
        out_ready64 = 1'b0;
        a64 = '0;
        b64 = '0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready8, 1'b1);
        check_eq("rst_out_valid", out_valid8, 1'b0);
        check_eq("rst_busy", busy8, 1'b0);
        check_eq("rst_product", product8, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 13 * 11 = 143
        op8("t1", 8'd13, 8'd11, 1'b1, 16'h008F, 8);
        // 255 * 255
        op8("t2", 8'hFF, 8'hFF, 1'b1, 16'hFE01, 8);

        // Zero operand
`ifdef MUL_SEQ_ZERO_SKIP_EN
        zlat = 0;
`else
        zlat = 8;
`endif
        op8("t4", 8'h00, 8'h5A, 1'b1, 16'h0000, zlat);

        // Held DONE with back-pressure; in_valid meanwhile must be ignored.
        op8("t3", 8'h80, 8'h02, 1'b0, 16'h0100, 8);
        a8 = 8'h11;
        b8 = 8'h22;
        in_valid8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("t3_hold_prod", product8, 16'h0100);
            check_eq("t3_hold_valid", out_valid8, 1'b1);
            check_eq("t3_hold_rdy", in_ready8, 1'b0);
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t3_rel_rdy", in_ready8, 1'b1);
        check_eq("t3_rel_valid", out_valid8, 1'b0);
        check_eq("t3_rel_prod", product8, 16'h0100);
        out_ready8 = 1'b0;

        // Asynchronous reset three cycles into RUN
        a8 = 8'd7;
        b8 = 8'd9;
        in_valid8 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_eq("t5_rst_valid", out_valid8, 1'b0);
        check_eq("t5_rst_busy", busy8, 1'b0);
        check_eq("t5_rst_prod", product8, 16'h0000);
        check_eq("t5_rst_rdy", in_ready8, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        op8("t5b", 8'd3, 8'd5, 1'b1, 16'h000F, 8);

        // N=64 full-width product
        out_ready64 = 1'b1;
        a64 = 64'hFFFF_FFFF_FFFF_FFFF;
        b64 = 64'hFFFF_FFFF_FFFF_FFFF;
        in_valid64 = 1'b1;
        @(posedge clk);
        #1;
        in_valid64 = 1'b0;
        a64 = '0;
        b64 = '0;
        lat64 = 0;
        while (!out_valid64 && lat64 < 200) begin
            @(posedge clk);
            #1;
            lat64++;
        end
        check_eq("w64_lat", lat64, 64);
        check_eq("w64_prod", product64, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        @(posedge clk);
        #1;
        check_eq("w64_rdy_back", in_ready64, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
